// File: rtl/stopwatch_display_writer.sv
// BCD stopwatch with run/stop/clear control that streams its ASCII digits into display RAM.
// Define LAP_HOLD_EN to enable the lap-hold feature; otherwise the lap input is ignored.
module stopwatch_display_writer #(
    parameter int DIGITS      = 4,
    parameter int TICK_PERIOD = 5000000,
    parameter int ADDR_W      = 6,
    parameter int BASE_ADDR   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic              lap,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [7:0]        wdata,
    output logic              running,
    output logic              overflow,
    output logic              tick
);

    localparam int CW = 4 * DIGITS;
    localparam int PW = $clog2(TICK_PERIOD);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0]     PRESC_MAX = PW'(TICK_PERIOD - 1);
    localparam logic [IW-1:0]     LAST_IDX  = IW'(DIGITS - 1);
    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);

    typedef enum logic {IDLE, BURST} wstate_t;

    logic [PW-1:0] presc;
    logic [CW-1:0] count;
    logic [CW-1:0] count_inc;
    logic          count_wrap;
    logic          carry;
    logic          tick_due;
    logic [CW-1:0] source;

    wstate_t       wstate;
    logic          force_burst;
    logic [CW-1:0] shadow;
    logic [IW-1:0] idx;
    logic [3:0]    next_digit;

    always_comb begin
        carry     = 1'b1;
        count_inc = count;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count[4*i +: 4] == 4'd9) begin
                    count_inc[4*i +: 4] = 4'd0;
                end else begin
                    count_inc[4*i +: 4] = count[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        count_wrap = carry;
    end

    // A stop or clear sampled on the same edge cancels a tick that was due.
    assign tick_due = running && !stop && !clear && (presc == PRESC_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            running  <= 1'b0;
            presc    <= '0;
            count    <= '0;
            overflow <= 1'b0;
            tick     <= 1'b0;
        end else begin
            tick <= tick_due;
            if (stop) begin
                running <= 1'b0;
            end else if (start) begin
                running <= 1'b1;
            end
            if (clear) begin
                count    <= '0;
                presc    <= '0;
                overflow <= 1'b0;
            end else if (running && !stop) begin
                if (presc == PRESC_MAX) begin
                    presc <= '0;
                    count <= count_inc;
                    if (count_wrap) begin
                        overflow <= 1'b1;
                    end
                end else begin
                    presc <= presc + PW'(1);
                end
            end
        end
    end

`ifdef LAP_HOLD_EN
    logic          hold;
    logic [CW-1:0] lap_count;

    // Capture uses the pre-increment count when lap coincides with a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold      <= 1'b0;
            lap_count <= '0;
        end else if (clear) begin
            hold <= 1'b0;
        end else if (lap) begin
            if (!hold) begin
                lap_count <= count;
                hold      <= 1'b1;
            end else begin
                hold <= 1'b0;
            end
        end
    end

    assign source = hold ? lap_count : count;
`else
    logic unused_lap;
    assign unused_lap = lap;
    assign source     = count;
`endif

    always_comb begin
        next_digit = 4'd0;
        for (int k = 0; k < DIGITS; k++) begin
            if (IW'(k) == idx + IW'(1)) begin
                next_digit = shadow[4*(DIGITS-1-k) +: 4];
            end
        end
    end

    // force_burst makes the first idle cycle after reset paint all zeros.
    always_ff @(posedge clk) begin
        if (rst) begin
            wstate      <= IDLE;
            force_burst <= 1'b1;
            shadow      <= '0;
            idx         <= '0;
            we          <= 1'b0;
            waddr       <= BASE;
            wdata       <= 8'h30;
        end else if (wstate == IDLE) begin
            if (force_burst || (source != shadow)) begin
                shadow      <= source;
                force_burst <= 1'b0;
                wstate      <= BURST;
                idx         <= '0;
                we          <= 1'b1;
                waddr       <= BASE;
                wdata       <= {4'h3, source[CW-1 -: 4]};
            end
        end else begin
            if (idx == LAST_IDX) begin
                wstate <= IDLE;
                we     <= 1'b0;
            end else begin
                idx   <= idx + IW'(1);
                waddr <= waddr + ADDR_W'(1);
                wdata <= {4'h3, next_digit};
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_display_writer.sv
// Bench for stopwatch_display_writer: integer reference model, RAM mirror and burst tables.
module tb_stopwatch_display_writer;

    localparam int D   = 4;
    localparam int TP  = 4;
    localparam int AW  = 6;
    localparam int BA  = 0;
    localparam int D2  = 4;
    localparam int TP2 = 2;
    localparam int AW2 = 4;
    localparam int BA2 = 14;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, stop, clear, lap;
    logic          we, running, overflow, tick;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;

    logic           rst2, start2, stop2, clear2, lap2;
    logic           we2, running2, overflow2, tick2;
    logic [AW2-1:0] waddr2;
    logic [7:0]     wdata2;

    stopwatch_display_writer #(.DIGITS(D), .TICK_PERIOD(TP), .ADDR_W(AW), .BASE_ADDR(BA)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .clear(clear), .lap(lap),
        .we(we), .waddr(waddr), .wdata(wdata), .running(running), .overflow(overflow), .tick(tick)
    );

    stopwatch_display_writer #(.DIGITS(D2), .TICK_PERIOD(TP2), .ADDR_W(AW2), .BASE_ADDR(BA2)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .stop(stop2), .clear(clear2), .lap(lap2),
        .we(we2), .waddr(waddr2), .wdata(wdata2), .running(running2), .overflow(overflow2), .tick(tick2)
    );

    logic [7:0] ram [0:63];
    always @(posedge clk) begin
        if (we) ram[waddr] <= wdata;
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] exp_q[$];

    int m_running, m_presc, m_count, m_over, m_hold, m_lap, m_tick;

    typedef struct {
        logic start;
        logic stop;
        logic clear;
        logic exp_running;
    } ctl_rec_t;

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [7:0] data;
        logic       tick;
    } burst_rec_t;

    ctl_rec_t   ctl_tbl[10];
    burst_rec_t b_tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] disp_ascii(input int v);
        logic [31:0] r;
        int p;
        r = '0;
        p = 1;
        for (int k = 0; k < D; k++) begin
            r[8*k +: 8] = 8'(48 + (v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [31:0] ram_word();
        return {ram[BA], ram[BA+1], ram[BA+2], ram[BA+3]};
    endfunction

    // Advance one clock: the model follows the stopwatch rules in plain integers.
    task automatic step();
        int t;
        if (rst) begin
            m_running = 0; m_presc = 0; m_count = 0; m_over = 0;
            m_hold = 0; m_lap = 0; m_tick = 0;
        end else begin
            t = (m_running != 0 && !stop && !clear && m_presc == TP - 1) ? 1 : 0;
`ifdef LAP_HOLD_EN
            if (clear) m_hold = 0;
            else if (lap) begin
                if (m_hold == 0) begin
                    m_lap  = m_count;
                    m_hold = 1;
                end else begin
                    m_hold = 0;
                end
            end
`endif
            if (clear) begin
                m_count = 0; m_presc = 0; m_over = 0;
            end else if (m_running != 0 && !stop) begin
                if (m_presc == TP - 1) begin
                    m_presc = 0;
                    if (m_count == 10 ** D - 1) begin
                        m_count = 0;
                        m_over  = 1;
                    end else begin
                        m_count = m_count + 1;
                    end
                end else begin
                    m_presc = m_presc + 1;
                end
            end
            if (stop) m_running = 0;
            else if (start) m_running = 1;
            m_tick = t;
        end
        @(posedge clk);
        #1;
        check("running", 32'(running), 32'(m_running));
        check("tick", 32'(tick), 32'(m_tick));
        check("overflow", 32'(overflow), 32'(m_over));
    endtask

    task automatic drain();
        stop = 1'b1;
        repeat (12) step();
        stop = 1'b0;
        check("ram_display", ram_word(), disp_ascii(m_hold != 0 ? m_lap : m_count));
    endtask

    task automatic run_until(input int target, input int budget);
        int b;
        b = budget;
        start = 1'b1;
        step();
        start = 1'b0;
        while (m_count != target && b > 0) begin
            step();
            b--;
        end
        check("run_until_reached", 32'(m_count), 32'(target));
    endtask

    task automatic wait_tick(input int budget);
        int b;
        b = budget;
        while (!tick && b > 0) begin
            step();
            b--;
        end
        check("tick_seen", 32'(tick), 32'd1);
    endtask

    initial begin
        int lat;
        int we_cnt;
        logic [15:0] e;
        logic [7:0] exp12 [4];

        ctl_tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b1};
        ctl_tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1};
        ctl_tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1};
        ctl_tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0};
        ctl_tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0};
        ctl_tbl[5] = '{1'b1, 1'b0, 1'b1, 1'b1};
        ctl_tbl[6] = '{1'b0, 1'b1, 1'b0, 1'b0};
        ctl_tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b0};
        ctl_tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b1};
        ctl_tbl[9] = '{1'b1, 1'b1, 1'b0, 1'b0};

        // TICK_PERIOD=2: burst of 0001 runs through two more ticks, one idle cycle, then 0003.
        b_tbl[0]  = '{1'b0, 4'd0,  8'h00, 1'b0};
        b_tbl[1]  = '{1'b0, 4'd0,  8'h00, 1'b1};
        b_tbl[2]  = '{1'b1, 4'd14, 8'h30, 1'b0};
        b_tbl[3]  = '{1'b1, 4'd15, 8'h30, 1'b1};
        b_tbl[4]  = '{1'b1, 4'd0,  8'h30, 1'b0};
        b_tbl[5]  = '{1'b1, 4'd1,  8'h31, 1'b1};
        b_tbl[6]  = '{1'b0, 4'd0,  8'h00, 1'b0};
        b_tbl[7]  = '{1'b1, 4'd14, 8'h30, 1'b0};
        b_tbl[8]  = '{1'b1, 4'd15, 8'h30, 1'b0};
        b_tbl[9]  = '{1'b1, 4'd0,  8'h30, 1'b0};
        b_tbl[10] = '{1'b1, 4'd1,  8'h33, 1'b0};
        b_tbl[11] = '{1'b0, 4'd0,  8'h00, 1'b0};
        b_tbl[12] = '{1'b0, 4'd0,  8'h00, 1'b0};

        exp12[0] = 8'h30; exp12[1] = 8'h30; exp12[2] = 8'h31; exp12[3] = 8'h32;

        rst = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
        rst2 = 1'b1; start2 = 1'b0; stop2 = 1'b0; clear2 = 1'b0; lap2 = 1'b0;
        m_running = 0; m_presc = 0; m_count = 0; m_over = 0; m_hold = 0; m_lap = 0; m_tick = 0;

        // Clock/reset: values held in reset
        repeat (2) step();
        check("rst_we", 32'(we), 32'd0);
        check("rst_waddr", 32'(waddr), 32'(BA));
        check("rst_wdata", 32'(wdata), 32'h30);
        check("rst2_waddr", 32'(waddr2), 32'(BA2));

        // Forced zero burst after reset release
        for (int k = 0; k < D; k++) exp_q.push_back({8'(BA + k), 8'h30});
        rst = 1'b0;
        rst2 = 1'b0;
        for (int k = 0; k < D; k++) begin
            step();
            check("zero_burst_we", 32'(we), 32'd1);
            if (we) begin
                if (exp_q.size() == 0) begin
                    check("zero_burst_extra", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("zero_burst_write", {16'd0, 8'(waddr), wdata}, {16'd0, e});
                end
            end
            check("zero_burst2", {15'd0, we2, 8'(waddr2), wdata2}, {15'd0, 1'b1, 8'((BA2 + k) % 16), 8'h30});
        end
        step();
        check("zero_burst_end", 32'(we), 32'd0);
        check("zero_burst_end2", 32'(we2), 32'd0);
        check("zero_burst_q_empty", 32'(exp_q.size()), 32'd0);

        // Snapshot burst under back-to-back ticks, address wrap at top of RAM
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        check("dut2_running", 32'(running2), 32'd1);
        for (int i = 0; i < 13; i++) begin
            if (i == 6) stop2 = 1'b1;
            step();
            check("dut2_we", 32'(we2), 32'(b_tbl[i].we));
            check("dut2_tick", 32'(tick2), 32'(b_tbl[i].tick));
            if (b_tbl[i].we) begin
                check("dut2_waddr", 32'(waddr2), 32'(b_tbl[i].addr));
                check("dut2_wdata", 32'(wdata2), 32'(b_tbl[i].data));
            end
        end
        stop2 = 1'b0;
        check("dut2_stopped", 32'(running2), 32'd0);

        // Run-control table
        for (int i = 0; i < 10; i++) begin
            start = ctl_tbl[i].start;
            stop  = ctl_tbl[i].stop;
            clear = ctl_tbl[i].clear;
            step();
            check("ctl_running", 32'(running), 32'(ctl_tbl[i].exp_running));
        end
        start = 1'b0; stop = 1'b0; clear = 1'b0;

        // First tick latency, then the 12th tick burst
        clear = 1'b1;
        step();
        clear = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= TP; i++) begin
            step();
            check("first_tick_latency", 32'(tick), 32'(i == TP));
        end
        run_until(11, 200);
        drain();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= TP; i++) step();
        check("tick12", 32'(tick), 32'd1);
        for (int k = 0; k < D; k++) begin
            step();
            check("burst12", {15'd0, we, 8'(waddr), wdata}, {15'd0, 1'b1, 8'(BA + k), exp12[k]});
        end
        step();
        check("burst12_end", 32'(we), 32'd0);
        drain();

        // start+stop together freezes the prescaler mid-period
        clear = 1'b1;
        step();
        clear = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        start = 1'b1;
        stop = 1'b1;
        step();
        start = 1'b0;
        stop = 1'b0;
        check("start_stop_running", 32'(running), 32'd0);
        repeat (3) step();
        start = 1'b1;
        step();
        start = 1'b0;
        lat = 0;
        while (!tick && lat < 10) begin
            step();
            lat++;
        end
        check("resume_latency", 32'(lat), 32'd2);
        drain();

        // Lap hold at 0042 while the count runs on to 0047
        clear = 1'b1;
        step();
        clear = 1'b0;
        run_until(42, 400);
        drain();
        check("lap_pre", ram_word(), disp_ascii(42));
        lap = 1'b1;
        step();
        lap = 1'b0;
        we_cnt = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int b = 0; b < 40 && m_count != 47; b++) begin
            step();
            if (we) we_cnt++;
        end
        check("lap_count", 32'(m_count), 32'd47);
`ifdef LAP_HOLD_EN
        check("held_no_bursts", 32'(we_cnt), 32'd0);
`else
        check("live_bursts", 32'(we_cnt > 0), 32'd1);
`endif
        drain();
        lap = 1'b1;
        step();
        lap = 1'b0;
        drain();
        check("lap_release", ram_word(), disp_ascii(47));

        // Randomized control against the model
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 200; c++) begin
                start = ($urandom_range(0, 7) == 0);
                stop  = ($urandom_range(0, 11) == 0);
                clear = ($urandom_range(0, 39) == 0);
                lap   = ($urandom_range(0, 29) == 0);
                step();
            end
            start = 1'b0; stop = 1'b0; clear = 1'b0; lap = 1'b0;
            drain();
        end

        // Overflow: 9999 -> 0000
        clear = 1'b1;
        step();
        clear = 1'b0;
        run_until(9999, 45000);
        drain();
        check("ovf_pre_flag", 32'(overflow), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_tick(10);
        stop = 1'b1;
        check("ovf_flag", 32'(overflow), 32'd1);
        for (int k = 0; k < D; k++) begin
            step();
            check("ovf_burst", {15'd0, we, 8'(waddr), wdata}, {15'd0, 1'b1, 8'(BA + k), 8'h30});
        end
        stop = 1'b0;
        drain();
        check("ovf_ram", ram_word(), disp_ascii(0));
        check("ovf_sticky", 32'(overflow), 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
